branch_resolver_pc: RTL and testbench

//  Consumes the branch comparator flags (EQ/LT/LTU) together with execute-stage decode info.

---
 rtl/branch_resolver_pc.sv | 173 +++++++++++++++++
 tb/tb_branch_resolver_pc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolver_pc.sv
// branch_resolver_pc
//   Resolves B-type / JAL / JALR in the execute stage, owns the fetch PC,
//   drives fetch redirect and holds a timed flush after every redirect.
//
//   State table
//     RUN   | normal fetch, taken instructions are evaluated
//     FLUSH | bubble window after a redirect, decode inputs ignored
//
// Ports
//   CLK, RST (sync, active-low), STALL
//   VALID, IS_BRANCH, IS_JAL, IS_JALR, BR_TYPE   execute-stage decode
//   EQ, LT, LTU                                 comparator flags
//   PC_EX, IMM, RS1                             target operands
//   PC                                          registered fetch PC
//   LINK                                        PC_EX+4 (combinational)
//   REDIRECT, FLUSH, MISALIGN                   registered control outputs
module branch_resolver_pc #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = 32'h100,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            VALID,
    input  logic            IS_BRANCH,
    input  logic            IS_JAL,
    input  logic            IS_JALR,
    input  logic [2:0]      BR_TYPE,
    input  logic            EQ,
    input  logic            LT,
    input  logic            LTU,
    input  logic [XLEN-1:0] PC_EX,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] LINK,
    output logic            REDIRECT,
    output logic            FLUSH,
    output logic            MISALIGN
);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic            cond;
    logic            take;
    logic            mis;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_seq;

    assign LINK     = PC_EX + XLEN'(4);
    assign jalr_sum = RS1 + IMM;
    assign pc_seq   = pc_q + XLEN'(4);

    always_comb begin
        cond = 1'b0;
        case (BR_TYPE)
            3'b000:  cond = EQ;
            3'b001:  cond = !EQ;
            3'b100:  cond = LT;
            3'b101:  cond = !LT;
            3'b110:  cond = LTU;
            3'b111:  cond = !LTU;
            default: cond = 1'b0;
        endcase
    end

    // JALR wins over JAL, which wins over a branch, when decode flags overlap.
    always_comb begin
        target = PC_EX + IMM;
        if (IS_JALR) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    assign take = VALID & (IS_JALR | IS_JAL | (IS_BRANCH & cond));
    assign mis  = (target[1:0] != 2'b00);

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!STALL && take && (FLUSH_CYCLES > 0)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (!STALL) begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic (values registered on the next edge)
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        flush_d    = flush_q;
        case (state_q)
            ST_RUN: begin
                if (!STALL) begin
                    if (take) begin
                        pc_d       = mis ? TRAP_VEC : target;
                        redirect_d = 1'b1;
                        misalign_d = mis;
                        flush_d    = (FLUSH_CYCLES > 0);
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (!STALL) begin
                    pc_d = pc_seq;
                    if (cnt_q == 3'd0) begin
                        flush_d = 1'b0;
                    end
                end
            end
            default: begin
                flush_d = 1'b0;
            end
        endcase
    end

    assign PC       = pc_q;
    assign REDIRECT = redirect_q;
    assign FLUSH    = flush_q;
    assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_branch_resolver_pc.sv
module tb_branch_resolver_pc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL;
    logic        VALID;
    logic        IS_BRANCH;
    logic        IS_JAL;
    logic        IS_JALR;
    logic [2:0]  BR_TYPE;
    logic        EQ;
    logic        LT;
    logic        LTU;
    logic [31:0] PC_EX;
    logic [31:0] IMM;
    logic [31:0] RS1;
    logic [31:0] PC;
    logic [31:0] LINK;
    logic        REDIRECT;
    logic        FLUSH;
    logic        MISALIGN;

    int checks = 0;
    int errors = 0;

    branch_resolver_pc dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .VALID(VALID),
        .IS_BRANCH(IS_BRANCH), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR),
        .BR_TYPE(BR_TYPE), .EQ(EQ), .LT(LT), .LTU(LTU),
        .PC_EX(PC_EX), .IMM(IMM), .RS1(RS1),
        .PC(PC), .LINK(LINK), .REDIRECT(REDIRECT), .FLUSH(FLUSH),
        .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // PC, REDIRECT, FLUSH, MISALIGN in one call
    task automatic chk_all(input string tag, input logic [31:0] pc_e,
                           input logic rd_e, input logic fl_e, input logic ms_e);
        chk({tag, ".pc"}, PC, pc_e);
        chk({tag, ".redirect"}, {31'b0, REDIRECT}, {31'b0, rd_e});
        chk({tag, ".flush"}, {31'b0, FLUSH}, {31'b0, fl_e});
        chk({tag, ".misalign"}, {31'b0, MISALIGN}, {31'b0, ms_e});
    endtask

    task automatic clr();
        VALID = 0; IS_BRANCH = 0; IS_JAL = 0; IS_JALR = 0;
        BR_TYPE = 3'b000; EQ = 0; LT = 0; LTU = 0;
    endtask

    initial begin
        RST = 0; STALL = 0; PC_EX = '0; IMM = '0; RS1 = '0;
        clr();

        // reset
        tick(); tick();
        chk_all("reset", 32'h0, 0, 0, 0);
        RST = 1;
        tick(); chk_all("seq1", 32'h4, 0, 0, 0);
        tick(); chk_all("seq2", 32'h8, 0, 0, 0);
        tick(); chk_all("seq3", 32'hC, 0, 0, 0);

        // BEQ taken
        VALID = 1; IS_BRANCH = 1; BR_TYPE = 3'b000; EQ = 1;
        PC_EX = 32'h40; IMM = 32'h20;
        tick(); chk_all("beq_t", 32'h60, 1, 1, 0);
        clr();
        tick(); chk_all("beq_f1", 32'h64, 0, 1, 0);
        tick(); chk_all("beq_f2", 32'h68, 0, 0, 0);

        // BEQ not taken
        VALID = 1; IS_BRANCH = 1; BR_TYPE = 3'b000; EQ = 0;
        tick(); chk_all("beq_nt", 32'h6C, 0, 0, 0);

        // BNE taken
        BR_TYPE = 3'b001; EQ = 0; PC_EX = 32'h80; IMM = 32'h8;
        tick(); chk_all("bne_t", 32'h88, 1, 1, 0);
        clr();
        tick(); tick(); chk_all("bne_end", 32'h90, 0, 0, 0);

        // BGEU taken
        VALID = 1; IS_BRANCH = 1; BR_TYPE = 3'b111; LTU = 0;
        PC_EX = 32'h100; IMM = 32'h40;
        tick(); chk_all("bgeu_t", 32'h140, 1, 1, 0);
        clr();
        tick(); tick(); chk_all("bgeu_end", 32'h148, 0, 0, 0);

        // BLT not taken
        VALID = 1; IS_BRANCH = 1; BR_TYPE = 3'b100; LT = 0;
        tick(); chk_all("blt_nt", 32'h14C, 0, 0, 0);

        // reserved funct3 never taken
        BR_TYPE = 3'b010; EQ = 1; LT = 1; LTU = 1;
        tick(); chk_all("rsvd_nt", 32'h150, 0, 0, 0);

        // JALR, bit 0 cleared
        clr();
        VALID = 1; IS_JALR = 1; IS_BRANCH = 1; PC_EX = 32'h200;
        RS1 = 32'h1001; IMM = 32'h10;
        #1 chk("jalr_link", LINK, 32'h204);
        tick(); chk_all("jalr", 32'h1010, 1, 1, 0);
        clr();
        tick(); tick(); chk_all("jalr_end", 32'h1018, 0, 0, 0);

        // JAL wrap-around
        VALID = 1; IS_JAL = 1; PC_EX = 32'hFFFF_FFF0; IMM = 32'h20;
        #1 chk("jal_link", LINK, 32'hFFFF_FFF4);
        tick(); chk_all("jal_wrap", 32'h10, 1, 1, 0);
        clr();
        tick(); tick(); chk_all("jal_end", 32'h18, 0, 0, 0);

        // misaligned JAL target vectors to trap
        VALID = 1; IS_JAL = 1; PC_EX = 32'h40; IMM = 32'h6;
        tick(); chk_all("mis", 32'h100, 1, 1, 1);
        clr();
        tick(); chk_all("mis_f1", 32'h104, 0, 1, 0);
        tick(); chk_all("mis_f2", 32'h108, 0, 0, 0);

        // stall mid-flush; taken input during flush ignored
        VALID = 1; IS_JAL = 1; PC_EX = 32'h300; IMM = 32'h10;
        tick(); chk_all("st_rd", 32'h310, 1, 1, 0);
        STALL = 1;
        tick(); chk_all("st_h1", 32'h310, 0, 1, 0);
        tick(); chk_all("st_h2", 32'h310, 0, 1, 0);
        tick(); chk_all("st_h3", 32'h310, 0, 1, 0);
        STALL = 0;
        tick(); chk_all("st_f1", 32'h314, 0, 1, 0);
        tick(); chk_all("st_f2", 32'h318, 0, 0, 0);
        // back-to-back: same taken JAL right after flush drops
        tick(); chk_all("b2b", 32'h310, 1, 1, 0);

        // reset mid-flush
        RST = 0;
        tick(); chk_all("rst_fl", 32'h0, 0, 0, 0);
        RST = 1; clr();

        // stall in RUN holds PC even with a taken instruction present
        STALL = 1; VALID = 1; IS_JAL = 1; PC_EX = 32'h500; IMM = 32'h20;
        tick(); chk_all("run_stall", 32'h0, 0, 0, 0);
        STALL = 0; clr();
        tick(); chk_all("run_go", 32'h4, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
